// File: rtl/relu_pool_requant.sv
// Bias + ReLU + requantise-to-int8 + 2x2/stride-2 max pooling over a conv output BRAM.
// Walks the map one pooling window at a time and streams pooled pixels out on a valid-only port.
module relu_pool_requant #(
    parameter int MAPSIZE = 28,
    parameter int SHIFT   = 8,
    parameter int ADDR_W  = $clog2(MAPSIZE * MAPSIZE)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic signed [31:0]  bias,
    output logic [ADDR_W-1:0]   mem_rd_addr,
    output logic                mem_rd_en,
    input  logic signed [31:0]  mem_rd_data,
    output logic                data_valid_out,
    output logic signed [7:0]   pixel_out,
    output logic                busy,
    output logic                all_done
);

    localparam int P    = MAPSIZE / 2;
    localparam int PC_W = (P > 1) ? $clog2(P) : 1;

    if (MAPSIZE % 2 != 0) begin : g_bad_mapsize
        $error("relu_pool_requant: MAPSIZE must be even");
    end

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic                busy_q, busy_d;
    logic                all_done_q, all_done_d;
    logic                rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [1:0]          elem_q, elem_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [PC_W-1:0]     pr_q, pr_d;
    logic                p1_valid_q, p1_valid_d;
    logic [1:0]          p1_elem_q, p1_elem_d;
    logic                s2_valid_q, s2_valid_d;
    logic [1:0]          s2_elem_q, s2_elem_d;
    logic [7:0]          s2_val_q, s2_val_d;
    logic [7:0]          max_q, max_d;
    logic [7:0]          pix_q, pix_d;
    logic                valid_q, valid_d;

    logic [1:0]          elem_n;
    logic [PC_W-1:0]     pc_n, pr_n;
    logic                rd_last;
    int                  addr_i;
    logic signed [32:0]  sum_v;
    logic signed [32:0]  relu_v;
    logic [7:0]          win_max;

    // Next window/element position and the BRAM address it maps to.
    always_comb begin
        elem_n  = elem_q + 2'd1;
        pc_n    = pc_q;
        pr_n    = pr_q;
        if (elem_q == 2'd3) begin
            if (pc_q == PC_W'(P - 1)) begin
                pc_n = '0;
                pr_n = pr_q + 1'b1;
            end else begin
                pc_n = pc_q + 1'b1;
            end
        end
        rd_last = (elem_q == 2'd3) && (pc_q == PC_W'(P - 1)) && (pr_q == PC_W'(P - 1));
        addr_i  = int'(pr_n) * 2 * MAPSIZE + int'(pc_n) * 2 + int'(elem_n[0])
                + (elem_n[1] ? MAPSIZE : 0);
    end

    // Requantise: 33-bit sum cannot overflow, negatives clamp to 0, large values to 127.
    always_comb begin
        sum_v  = $signed({mem_rd_data[31], mem_rd_data}) + $signed({bias[31], bias});
        relu_v = sum_v[32] ? 33'sd0 : (sum_v >>> SHIFT);
        s2_val_d = (relu_v > 33'sd127) ? 8'd127 : relu_v[7:0];
    end

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        all_done_d = 1'b0;
        rd_en_d    = rd_en_q;
        rd_addr_d  = rd_addr_q;
        elem_d     = elem_q;
        pc_d       = pc_q;
        pr_d       = pr_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_READ;
                    busy_d    = 1'b1;
                    rd_en_d   = 1'b1;
                    rd_addr_d = '0;
                    elem_d    = '0;
                    pc_d      = '0;
                    pr_d      = '0;
                end
            end
            S_READ: begin
                if (rd_last) begin
                    state_d = S_DRAIN;
                    rd_en_d = 1'b0;
                end else begin
                    elem_d    = elem_n;
                    pc_d      = pc_n;
                    pr_d      = pr_n;
                    rd_addr_d = ADDR_W'(addr_i);
                end
            end
            S_DRAIN: begin
                // Nothing else is in flight once the final window's pixel is out.
                if (valid_q) begin
                    state_d    = S_DONE;
                    all_done_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Element tags ride alongside the read so the max stage knows window boundaries.
    always_comb begin
        p1_valid_d = rd_en_q;
        p1_elem_d  = elem_q;
        s2_valid_d = p1_valid_q;
        s2_elem_d  = p1_elem_q;
        max_d      = max_q;
        pix_d      = pix_q;
        valid_d    = 1'b0;
        win_max    = (s2_val_q > max_q) ? s2_val_q : max_q;
        if (s2_valid_q) begin
            if (s2_elem_q == 2'd0) begin
                max_d = s2_val_q;
            end else begin
                max_d = win_max;
            end
            if (s2_elem_q == 2'd3) begin
                pix_d   = win_max;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            all_done_q <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            elem_q     <= '0;
            pc_q       <= '0;
            pr_q       <= '0;
            p1_valid_q <= 1'b0;
            p1_elem_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_elem_q  <= '0;
            s2_val_q   <= '0;
            max_q      <= '0;
            pix_q      <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            all_done_q <= all_done_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            elem_q     <= elem_d;
            pc_q       <= pc_d;
            pr_q       <= pr_d;
            p1_valid_q <= p1_valid_d;
            p1_elem_q  <= p1_elem_d;
            s2_valid_q <= s2_valid_d;
            s2_elem_q  <= s2_elem_d;
            s2_val_q   <= s2_val_d;
            max_q      <= max_d;
            pix_q      <= pix_d;
            valid_q    <= valid_d;
        end
    end

    assign mem_rd_addr    = rd_addr_q;
    assign mem_rd_en      = rd_en_q;
    assign data_valid_out = valid_q;
    assign pixel_out      = $signed(pix_q);
    assign busy           = busy_q;
    assign all_done       = all_done_q;

endmodule

// File: tb/tb_relu_pool_requant.sv
// Directed bench for relu_pool_requant: a 4x4 ordering instance plus two 28x28 instances
// (SHIFT=8 and SHIFT=1), each fed by a one-cycle-latency BRAM model.
module tb_relu_pool_requant;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int checks = 0;
    int errors = 0;

    // ---------------- 4x4, SHIFT=0 instance (address = data) ----------------
    logic               start_s = 1'b0;
    logic [3:0]         addr_s;
    logic               en_s, valid_s, busy_s, done_s;
    logic signed [31:0] data_s = '0;
    logic signed [7:0]  pix_s;

    relu_pool_requant #(.MAPSIZE(4), .SHIFT(0)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .bias(32'sd0),
        .mem_rd_addr(addr_s), .mem_rd_en(en_s), .mem_rd_data(data_s),
        .data_valid_out(valid_s), .pixel_out(pix_s), .busy(busy_s), .all_done(done_s)
    );
    always @(posedge clk) if (en_s) data_s <= {28'd0, addr_s};

    // ---------------- 28x28, SHIFT=8 instance ----------------
    logic               start_a = 1'b0;
    logic signed [31:0] bias_a = '0;
    logic signed [31:0] fill_a = '0;
    logic [9:0]         addr_a;
    logic               en_a, valid_a, busy_a, done_a;
    logic signed [31:0] data_a = '0;
    logic signed [7:0]  pix_a;

    relu_pool_requant #(.MAPSIZE(28), .SHIFT(8)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .bias(bias_a),
        .mem_rd_addr(addr_a), .mem_rd_en(en_a), .mem_rd_data(data_a),
        .data_valid_out(valid_a), .pixel_out(pix_a), .busy(busy_a), .all_done(done_a)
    );
    always @(posedge clk) if (en_a) data_a <= fill_a;

    // ---------------- 28x28, SHIFT=1 instance ----------------
    logic               start_b = 1'b0;
    logic signed [31:0] bias_b = '0;
    logic signed [31:0] fill_b = '0;
    logic [9:0]         addr_b;
    logic               en_b, valid_b, busy_b, done_b;
    logic signed [31:0] data_b = '0;
    logic signed [7:0]  pix_b;

    relu_pool_requant #(.MAPSIZE(28), .SHIFT(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .bias(bias_b),
        .mem_rd_addr(addr_b), .mem_rd_en(en_b), .mem_rd_data(data_b),
        .data_valid_out(valid_b), .pixel_out(pix_b), .busy(busy_b), .all_done(done_b)
    );
    always @(posedge clk) if (en_b) data_b <= fill_b;

    // ---------------- monitors (sample on falling edge) ----------------
    logic [3:0] addr_q_s[$];
    logic [7:0] pix_q_s[$];
    logic [7:0] pix_q_a[$];
    logic [7:0] pix_q_b[$];
    int         vcyc_q_a[$];
    logic [7:0] exp_q[$];
    int done_cnt_s = 0, done_cnt_a = 0, done_cnt_b = 0;
    int rd_cnt_a = 0, rd_first_a = -1, rd_last_a = -1, done_cyc_a = -1;
    int start_idx_a = 0;
    bit busy_at_a[0:1023];

    always @(negedge clk) begin
        int rel;
        if (en_s) addr_q_s.push_back(addr_s);
        if (valid_s) pix_q_s.push_back(pix_s);
        if (done_s) done_cnt_s++;
        rel = edge_cnt - start_idx_a;
        if (en_a) begin
            rd_cnt_a++;
            if (rd_first_a < 0) rd_first_a = rel;
            rd_last_a = rel;
        end
        if (valid_a) begin
            pix_q_a.push_back(pix_a);
            vcyc_q_a.push_back(rel);
        end
        if (done_a) begin
            done_cnt_a++;
            done_cyc_a = rel;
        end
        if (rel >= 0 && rel < 1024) busy_at_a[rel] = busy_a;
        if (valid_b) pix_q_b.push_back(pix_b);
        if (done_b) done_cnt_b++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic begin_a(input logic signed [31:0] fill, input logic signed [31:0] b);
        @(negedge clk); #1;
        fill_a = fill;
        bias_a = b;
        pix_q_a.delete();
        vcyc_q_a.delete();
        rd_cnt_a = 0; rd_first_a = -1; rd_last_a = -1;
        done_cnt_a = 0; done_cyc_a = -1;
        for (int i = 0; i < 1024; i++) busy_at_a[i] = 1'b0;
        start_idx_a = edge_cnt;
        start_a = 1'b1;
        @(negedge clk); #1;
        start_a = 1'b0;
    endtask

    task automatic wait_done_a(input string tag);
        int n = 0;
        while (done_cnt_a == 0 && n < 2000) begin
            @(negedge clk); #1;
            n++;
        end
        check({tag, "_done_seen"}, int'(done_cnt_a != 0), 1);
        repeat (4) @(negedge clk);
        #1;
    endtask

    task automatic check_pix_a(input string tag, input logic [7:0] exp);
        int bad = 0;
        int first_bad = 0;
        foreach (pix_q_a[i]) if (pix_q_a[i] !== exp) begin
            if (bad == 0) first_bad = int'(pix_q_a[i]);
            bad++;
        end
        check({tag, "_count"}, pix_q_a.size(), 196);
        check({tag, "_bad_pixels"}, bad, 0);
        if (bad != 0) check({tag, "_first_bad_value"}, first_bad, int'(exp));
        check({tag, "_done_pulses"}, done_cnt_a, 1);
    endtask

    task automatic pass_b(input string tag, input logic signed [31:0] fill,
                          input logic signed [31:0] b, input logic [7:0] exp);
        int n = 0;
        int bad = 0;
        @(negedge clk); #1;
        fill_b = fill;
        bias_b = b;
        pix_q_b.delete();
        done_cnt_b = 0;
        start_b = 1'b1;
        @(negedge clk); #1;
        start_b = 1'b0;
        while (done_cnt_b == 0 && n < 2000) begin
            @(negedge clk); #1;
            n++;
        end
        repeat (3) @(negedge clk);
        #1;
        foreach (pix_q_b[i]) if (pix_q_b[i] !== exp) bad++;
        check({tag, "_count"}, pix_q_b.size(), 196);
        check({tag, "_bad_pixels"}, bad, 0);
        check({tag, "_value0"}, (pix_q_b.size() > 0) ? int'(pix_q_b[0]) : -1, int'(exp));
        check({tag, "_done_pulses"}, done_cnt_b, 1);
    endtask

    initial begin
        int bad;
        int n;
        int r0, p0;
        logic [3:0] exp_addr[16];
        exp_addr = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd2, 4'd3, 4'd6, 4'd7,
                     4'd8, 4'd9, 4'd12, 4'd13, 4'd10, 4'd11, 4'd14, 4'd15};

        // ---- reset ----
        repeat (3) @(negedge clk);
        check("rst_valid", int'(valid_a), 0);
        check("rst_pixel", int'(pix_a), 0);
        check("rst_busy", int'(busy_a), 0);
        check("rst_done", int'(done_a), 0);
        check("rst_rd_en", int'(en_a), 0);
        check("rst_rd_addr", int'(addr_a), 0);
        #1 rst = 1'b0;

        // ---- 4x4 ordering ----
        @(negedge clk); #1;
        addr_q_s.delete(); pix_q_s.delete(); done_cnt_s = 0;
        start_s = 1'b1;
        @(negedge clk); #1;
        start_s = 1'b0;
        n = 0;
        while (done_cnt_s == 0 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        repeat (4) @(negedge clk);
        #1;
        check("s_addr_count", addr_q_s.size(), 16);
        bad = 0;
        for (int i = 0; i < 16; i++)
            if (i >= addr_q_s.size() || addr_q_s[i] !== exp_addr[i]) bad++;
        check("s_addr_order_bad", bad, 0);
        exp_q = '{8'd5, 8'd7, 8'd13, 8'd15};
        check("s_pix_count", pix_q_s.size(), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("s_pix%0d", i), (i < pix_q_s.size()) ? int'(pix_q_s[i]) : -1,
                  int'(exp_q[i]));
        check("s_done_pulses", done_cnt_s, 1);

        // ---- ReLU ----
        begin_a(-32'sd1000, 32'sd0);
        wait_done_a("relu");
        check_pix_a("relu", 8'd0);

        // ---- saturation + timing ----
        begin_a(32'sd1 <<< 20, 32'sd0);
        wait_done_a("sat");
        check_pix_a("sat", 8'd127);
        check("t_first_valid", (vcyc_q_a.size() > 0) ? vcyc_q_a[0] : -1, 7);
        check("t_last_valid", (vcyc_q_a.size() > 0) ? vcyc_q_a[vcyc_q_a.size()-1] : -1, 787);
        bad = 0;
        for (int i = 1; i < vcyc_q_a.size(); i++) if (vcyc_q_a[i] - vcyc_q_a[i-1] != 4) bad++;
        check("t_spacing_bad", bad, 0);
        check("t_done_cycle", done_cyc_a, 788);
        check("t_busy_c1", int'(busy_at_a[1]), 1);
        check("t_busy_c788", int'(busy_at_a[788]), 1);
        check("t_busy_c789", int'(busy_at_a[789]), 0);
        check("t_rd_count", rd_cnt_a, 784);
        check("t_rd_first", rd_first_a, 1);
        check("t_rd_last", rd_last_a, 784);

        begin_a(32'sd32767, 32'sd0);
        wait_done_a("q32767");
        check_pix_a("q32767", 8'd127);
        begin_a(32'sd32512, 32'sd0);
        wait_done_a("q32512");
        check_pix_a("q32512", 8'd127);
        begin_a(32'sd32511, 32'sd0);
        wait_done_a("q32511");
        check_pix_a("q32511", 8'd126);

        // ---- bias ----
        pass_b("bias_m50", 32'sd100, -32'sd50, 8'd25);
        pass_b("bias_m200", 32'sd100, -32'sd200, 8'd0);
        pass_b("bias_max", 32'sh7fffffff, 32'sh7fffffff, 8'd127);

        // ---- start during READ ignored ----
        begin_a(32'sd1 <<< 20, 32'sd0);
        repeat (100) @(negedge clk);
        #1 start_a = 1'b1;
        @(negedge clk); #1 start_a = 1'b0;
        wait_done_a("restart");
        repeat (20) @(negedge clk);
        #1;
        check_pix_a("restart", 8'd127);
        check("restart_rd_count", rd_cnt_a, 784);

        // ---- reset mid-pass ----
        begin_a(32'sd1 <<< 20, 32'sd0);
        repeat (300) @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", int'(valid_a), 0);
        check("mid_rst_pixel", int'(pix_a), 0);
        check("mid_rst_busy", int'(busy_a), 0);
        check("mid_rst_rd_en", int'(en_a), 0);
        check("mid_rst_rd_addr", int'(addr_a), 0);
        check("mid_rst_done", int'(done_a), 0);
        #1 rst = 1'b0;
        r0 = rd_cnt_a;
        p0 = pix_q_a.size();
        repeat (900) @(negedge clk);
        #1;
        check("mid_rst_no_reads", rd_cnt_a, r0);
        check("mid_rst_no_valids", pix_q_a.size(), p0);
        check("mid_rst_no_done", done_cnt_a, 0);

        // ---- fresh pass after reset ----
        begin_a(32'sd32511, 32'sd0);
        wait_done_a("fresh");
        check_pix_a("fresh", 8'd126);
        check("fresh_first_valid", (vcyc_q_a.size() > 0) ? vcyc_q_a[0] : -1, 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/relu_pool_requant.md
Name: relu_pool_requant

Overview:
- Consumes the 32-bit convolution results that the conv engine writes into its output BRAM. The BRAM is a MAPSIZE x MAPSIZE raster with row-major addressing.
- For each element it adds a bias, applies ReLU, right-shifts and saturates the result to int8. It then applies 2x2 stride-2 max pooling.
- It streams the pooled int8 map out in raster order on a valid-only interface. That stream feeds the next conv layer's data_valid_in/pixel_in.

Parameters:
- MAPSIZE, 28, side length of the input (conv-output) map. Must be even; elaboration fails with $error otherwise.
- SHIFT, 8, arithmetic right-shift applied after bias/ReLU (requantisation scale).
- ADDR_W, $clog2(MAPSIZE*MAPSIZE), BRAM read-address width (derived; do not override).

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous reset, active-high.
- start, input, 1, begin one full map pass; sampled only in IDLE.
- bias, input, 32 signed, per-channel bias; must be held stable for the whole pass.
- mem_rd_addr, output, ADDR_W, BRAM read address.
- mem_rd_en, output, 1, BRAM read enable.
- mem_rd_data, input, 32 signed, BRAM read data; valid exactly 1 cycle after the cycle that mem_rd_en/addr are asserted.
- data_valid_out, output, 1, single-cycle pulse per pooled pixel.
- pixel_out, output, 8 signed, pooled pixel; range 0..127.
- busy, output, 1, high from the cycle after start is accepted through the cycle all_done pulses.
- all_done, output, 1, single-cycle pulse at end of pass.

Behaviour:
- Reset values: mem_rd_addr=0, mem_rd_en=0, data_valid_out=0, pixel_out=0, busy=0, all_done=0. Pipeline and counters are cleared and the FSM enters IDLE.
- Reset mid-pass aborts immediately: no further reads or valids are produced.
- FSM states: IDLE -> READ (start=1) -> DRAIN (last read issued) -> DONE (last output emitted) -> IDLE.
- In IDLE, start=0 keeps the FSM in IDLE. start is ignored in every state other than IDLE.
- Read order in READ: pooled output (pr,pc) is raster over P=MAPSIZE/2 rows and columns. For each output, 4 consecutive reads are issued at base, base+1, base+MAPSIZE, base+MAPSIZE+1, where base=2*pr*MAPSIZE+2*pc.
- mem_rd_en is high on exactly 4*P*P consecutive cycles, with no bubbles. Column wrap (pc=P-1 -> 0) advances pr. The row skip is handled by the base formula.
- Per-element arithmetic, performed in the stage that registers mem_rd_data:
  - v = mem_rd_data + bias, computed at 33-bit signed width, with no overflow.
  - r = (v<0) ? 0 : v >>> SHIFT.
  - q = (r>127) ? 127 : r[7:0].
- Max stage:
  - The first element of each window loads the running max.
  - Elements 2-4 are compared unsigned (all operands are in 0..127), and the running max keeps the larger value.
  - After element 4, the max is registered to pixel_out and data_valid_out pulses.
- Latency: if the 4th read of a window is issued in cycle t, data_valid_out=1 in cycle t+3. pixel_out holds its value until the next valid.
- Throughput: one output every 4 cycles, steady state.
- With start sampled at edge 0, reads occupy cycles 1..4*P*P and the first valid occurs in cycle 7.
- DRAIN waits for the last valid. all_done and busy-deassert timing:
  - all_done pulses in the cycle after the last data_valid_out.
  - busy drops in the cycle following the all_done pulse.
  - In that same cycle the FSM is in IDLE and may accept a new start.
- Exactly P*P valids are produced per pass.

Test Plan:
- Address/ordering, MAPSIZE=4, SHIFT=0, bias=0, mem[a]=a:
  - Read address sequence must be 0,1,4,5,2,3,6,7,8,9,12,13,10,11,14,15.
  - Outputs must be 5,7,13,15, with 4 valids then 1 all_done.
- ReLU: all mem=-1000, bias=0 -> every pixel_out=0, 196 valids (MAPSIZE=28).
- Saturation: mem=1<<20, SHIFT=8 -> 4096 clamps to 127 on every output. Also mem=32767, SHIFT=8 -> 127, and mem=32512 -> 127, mem=32511 -> 126.
- Bias: mem=100, SHIFT=1:
  - bias=-50 -> 25.
  - bias=-200 -> 0.
  - bias=2^31-1 with mem=2^31-1 -> 127, with no wrap to negative.
- Timing: MAPSIZE=28, start at edge 0:
  - First valid in cycle 7, valids spaced exactly 4 cycles, last valid in cycle 787.
  - all_done in cycle 788, busy low from cycle 789.
- Control: start pulsed during READ is ignored and the output count stays 196. rst asserted mid-pass means all outputs are 0 the next cycle and no further valids. A fresh start afterwards completes a full correct pass.
